// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - four-source prioritized interrupt controller (optional nesting via INT_NEST_EN)
module int_ctrl #(
    parameter logic [15:0] INT0_VEC  = 16'h0010,
    parameter logic [15:0] INT1_VEC  = 16'h0020,
    parameter logic [15:0] INT2_VEC  = 16'h0030,
    parameter logic [15:0] INT3_VEC  = 16'h0040,
    parameter logic [15:0] EN_ADDR   = 16'hC002,
    parameter logic [15:0] PEND_ADDR = 16'hC003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        int_req,
    output logic [15:0] int_vec,
    input  logic        int_ack,
    input  logic        rti
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  irq_q;
    logic [3:0]  pend;
    logic [3:0]  pend_next;
    logic [3:0]  en;
    logic        gie;
    logic [3:0]  insvc;
    logic [1:0]  id;

    logic [3:0]  rise;
    logic [3:0]  eligible;
    logic        en_wr;
    logic        pend_wr;
    logic        ack_take;
    logic        rti_take;
    logic [3:0]  insvc_low;
    logic [3:0]  insvc_after_rti;
    logic [3:0]  nest_cand;
    logic        launch;
    logic [3:0]  launch_src;
    logic [1:0]  launch_id;
    logic        unused_wdata;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        if (v[0])      first_set = 2'd0;
        else if (v[1]) first_set = 2'd1;
        else if (v[2]) first_set = 2'd2;
        else           first_set = 2'd3;
    endfunction

    function automatic logic [15:0] vector_of(input logic [1:0] i);
        case (i)
            2'd0:    vector_of = INT0_VEC;
            2'd1:    vector_of = INT1_VEC;
            2'd2:    vector_of = INT2_VEC;
            default: vector_of = INT3_VEC;
        endcase
    endfunction

    assign unused_wdata    = &{1'b0, wdata[15:5]};
    assign rise            = irq & ~irq_q;
    assign eligible        = pend & en & {4{gie}};
    assign en_wr           = we && (addr == EN_ADDR);
    assign pend_wr         = we && (addr == PEND_ADDR);
    assign ack_take        = (state == REQ) && int_ack;
    assign rti_take        = (state == SERVICE) && rti;
    assign insvc_low       = insvc & (~insvc + 4'd1);
    assign insvc_after_rti = insvc & ~insvc_low;

`ifdef INT_NEST_EN
    // Only sources strictly more urgent than the one currently in service may preempt it
    assign nest_cand = eligible & (insvc_low - 4'd1);
`else
    assign nest_cand = 4'b0000;
`endif

    // Register reads are combinational so data is valid in the same cycle as re
    always_comb begin
        rdata = 16'h0000;
        if (re && addr == EN_ADDR)
            rdata = {11'b0, gie, en};
        else if (re && addr == PEND_ADDR)
            rdata = {8'b0, insvc, pend};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; rti takes precedence over a nested request in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (eligible != 4'b0000) state_next = REQ;
            REQ:     if (int_ack) state_next = SERVICE;
            SERVICE: begin
                if (rti) begin
                    if (insvc_after_rti == 4'b0000) state_next = IDLE;
                end else if (nest_cand != 4'b0000) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: when a new request is launched and which source it carries
    always_comb begin
        launch     = 1'b0;
        launch_src = 4'b0000;
        case (state)
            IDLE: begin
                launch     = (eligible != 4'b0000);
                launch_src = eligible;
            end
            SERVICE: begin
                launch     = !rti && (nest_cand != 4'b0000);
                launch_src = nest_cand;
            end
            default: begin
                launch     = 1'b0;
                launch_src = 4'b0000;
            end
        endcase
        launch_id = first_set(launch_src);
    end

    // Request handshake: request, vector and id are frozen from launch until ack
    always_ff @(posedge clk) begin
        if (rst) begin
            int_req <= 1'b0;
            int_vec <= 16'h0000;
            id      <= 2'd0;
        end else if (launch) begin
            int_req <= 1'b1;
            int_vec <= vector_of(launch_id);
            id      <= launch_id;
        end else if (ack_take) begin
            int_req <= 1'b0;
        end
    end

    // Pending next value: clears first, then new edges override so a set always wins
    always_comb begin
        pend_next = pend;
        if (pend_wr)
            pend_next = pend_next & ~wdata[3:0];
        if (ack_take)
            pend_next[id] = 1'b0;
        pend_next = pend_next | rise;
    end

    // Edge detector, pending latch, enable register and in-service tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 4'b0000;
            pend  <= 4'b0000;
            en    <= 4'b0000;
            gie   <= 1'b0;
            insvc <= 4'b0000;
        end else begin
            irq_q <= irq;
            pend  <= pend_next;
            if (en_wr) begin
                en  <= wdata[3:0];
                gie <= wdata[4];
            end
            if (ack_take)
                insvc <= insvc | (4'b0001 << id);
            else if (rti_take)
                insvc <= insvc_after_rti;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed and randomized self-checking bench for int_ctrl
module tb_int_ctrl;

    localparam logic [15:0] EN_A   = 16'hC002;
    localparam logic [15:0] PEND_A = 16'hC003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq = 4'h0;
    logic [15:0] addr = 16'h0000;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        int_req;
    logic [15:0] int_vec;
    logic        int_ack = 1'b0;
    logic        rti = 1'b0;

    int tests = 0;
    int fails = 0;

    // reference model: sets of pending / enabled / in-service sources and an outstanding request
    logic [3:0] m_pend, m_en, m_insvc, m_prev;
    logic       m_gie, m_req;
    int         m_id;

    int_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .addr(addr), .we(we), .re(re),
        .wdata(wdata), .rdata(rdata), .int_req(int_req), .int_vec(int_vec),
        .int_ack(int_ack), .rti(rti)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a; re = 1'b1;
        #1;
        check(tag, rdata, exp);
        re = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq = v;
        tick();
        irq = 4'h0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_rti();
        rti = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = 4'h0; m_en = 4'h0; m_insvc = 4'h0; m_prev = 4'h0;
        m_gie = 1'b0; m_req = 1'b0; m_id = 0;
    endtask

    // one clock of the reference model, driven by the inputs currently applied
    task automatic model_step();
        logic [3:0] elig;
        logic [3:0] n_pend;
        int         li;
        int         w;
        if (rst) begin
            model_reset();
            return;
        end
        elig   = m_pend & m_en & {4{m_gie}};
        n_pend = m_pend;
        if (we && addr == PEND_A) n_pend = n_pend & ~wdata[3:0];
        if (m_req && int_ack)     n_pend[m_id] = 1'b0;
        n_pend = n_pend | (irq & ~m_prev);
        if (m_req) begin
            if (int_ack) begin
                m_insvc[m_id] = 1'b1;
                m_req = 1'b0;
            end
        end else if (m_insvc != 4'h0) begin
            li = 4;
            for (int i = 3; i >= 0; i--) if (m_insvc[i]) li = i;
            if (rti) begin
                m_insvc[li] = 1'b0;
            end else begin
`ifdef INT_NEST_EN
                w = -1;
                for (int i = li - 1; i >= 0; i--) if (elig[i]) w = i;
                if (w >= 0) begin
                    m_req = 1'b1;
                    m_id = w;
                end
`else
                w = -1;
`endif
            end
        end else begin
            w = -1;
            for (int i = 3; i >= 0; i--) if (elig[i]) w = i;
            if (w >= 0) begin
                m_req = 1'b1;
                m_id = w;
            end
        end
        if (we && addr == EN_A) begin
            m_en  = wdata[3:0];
            m_gie = wdata[4];
        end
        m_pend = n_pend;
        m_prev = irq;
    endtask

    initial begin
        logic [15:0] exp_rd;
        int          sel;

        // reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_req", {15'b0, int_req}, 16'h0000);
        check("reset_vec", int_vec, 16'h0000);
        rd_check("reset_en", EN_A, 16'h0000);
        rd_check("reset_pend", PEND_A, 16'h0000);
        rd_check("unmapped_read", 16'h1234, 16'h0000);

        // basic single-source flow and latency
        wr(EN_A, 16'h0011);
        rd_check("basic_en", EN_A, 16'h0011);
        pulse_irq(4'h1);
        check("basic_req_n1", {15'b0, int_req}, 16'h0000);
        rd_check("basic_pend_n1", PEND_A, 16'h0001);
        tick();
        check("basic_req_n2", {15'b0, int_req}, 16'h0001);
        check("basic_vec", int_vec, 16'h0010);
        tick();
        check("basic_req_hold", {15'b0, int_req}, 16'h0001);
        do_ack();
        check("basic_req_drop", {15'b0, int_req}, 16'h0000);
        rd_check("basic_insvc", PEND_A, 16'h0010);
        do_rti();
        rd_check("basic_after_rti", PEND_A, 16'h0000);

        // priority between simultaneous edges
        wr(EN_A, 16'h001F);
        pulse_irq(4'hA);
        tick();
        check("prio_req1", {15'b0, int_req}, 16'h0001);
        check("prio_vec1", int_vec, 16'h0020);
        do_ack();
        rd_check("prio_state", PEND_A, 16'h0028);
        tick();
        check("prio_no_req_in_svc", {15'b0, int_req}, 16'h0000);
        do_rti();
        check("prio_idle_no_req", {15'b0, int_req}, 16'h0000);
        tick();
        check("prio_req2", {15'b0, int_req}, 16'h0001);
        check("prio_vec2", int_vec, 16'h0040);
        do_ack();
        do_rti();

        // masking and write-1-to-clear
        wr(EN_A, 16'h000F);
        pulse_irq(4'h4);
        tick(); tick();
        check("mask_no_req", {15'b0, int_req}, 16'h0000);
        rd_check("mask_pend", PEND_A, 16'h0004);
        wr(PEND_A, 16'h0004);
        rd_check("mask_cleared", PEND_A, 16'h0000);
        wr(EN_A, 16'h001F);
        tick(); tick();
        check("mask_still_no_req", {15'b0, int_req}, 16'h0000);

        // committed request survives disabling
        pulse_irq(4'h8);
        tick();
        check("commit_req", {15'b0, int_req}, 16'h0001);
        wr(EN_A, 16'h0000);
        tick();
        check("commit_req_hold", {15'b0, int_req}, 16'h0001);
        check("commit_vec_hold", int_vec, 16'h0040);
        do_ack();
        check("commit_req_drop", {15'b0, int_req}, 16'h0000);
        do_rti();

        // reset while in service
        wr(EN_A, 16'h001F);
        pulse_irq(4'h1);
        tick();
        do_ack();
        pulse_irq(4'h2);
        tick();
        rd_check("rst_pre_state", PEND_A, 16'h0012);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_req", {15'b0, int_req}, 16'h0000);
        rd_check("rst_pend", PEND_A, 16'h0000);
        rd_check("rst_en", EN_A, 16'h0000);

        // a higher-priority source arriving during service
        wr(EN_A, 16'h001F);
        pulse_irq(4'h4);
        tick();
        do_ack();
        pulse_irq(4'h1);
        tick();
`ifdef INT_NEST_EN
        check("nest_req", {15'b0, int_req}, 16'h0001);
        check("nest_vec", int_vec, 16'h0010);
        rd_check("nest_pre_ack", PEND_A, 16'h0041);
        do_ack();
        rd_check("nest_insvc2", PEND_A, 16'h0050);
        do_rti();
        rd_check("nest_rti1", PEND_A, 16'h0040);
        do_rti();
        rd_check("nest_rti2", PEND_A, 16'h0000);
`else
        check("nonest_no_req", {15'b0, int_req}, 16'h0000);
        rd_check("nonest_state", PEND_A, 16'h0041);
        do_rti();
        check("nonest_idle", {15'b0, int_req}, 16'h0000);
        tick();
        check("nonest_req", {15'b0, int_req}, 16'h0001);
        check("nonest_vec", int_vec, 16'h0010);
        do_ack();
        do_rti();
`endif

        // randomized traffic against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            rst     = ($urandom % 200) == 0;
            irq     = irq ^ 4'(($urandom & $urandom));
            int_ack = m_req ? 1'($urandom % 2) : (($urandom % 16) == 0);
            rti     = (m_insvc != 4'h0) ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
            wdata   = 16'($urandom);
            sel     = $urandom % 8;
            we      = (sel < 2);
            if (sel == 0) begin
                addr = EN_A;
                wdata[4] = ($urandom % 4) != 0;
            end else if (sel == 1) begin
                addr = PEND_A;
            end else if (sel < 5) begin
                addr = EN_A;
            end else if (sel < 7) begin
                addr = PEND_A;
            end else begin
                addr = 16'($urandom);
                if (addr == EN_A || addr == PEND_A) addr = 16'h0000;
            end
            re = 1'b1;
            #1;
            check("rnd_req", {15'b0, int_req}, {15'b0, m_req});
            if (m_req) check("rnd_vec", int_vec, 16'(16 * (m_id + 1)));
            if (addr == EN_A)        exp_rd = {11'b0, m_gie, m_en};
            else if (addr == PEND_A) exp_rd = {8'b0, m_insvc, m_pend};
            else                     exp_rd = 16'h0000;
            check("rnd_rdata", rdata, exp_rd);
            model_step();
            tick();
        end
        rst = 1'b0; we = 1'b0; re = 1'b0; int_ack = 1'b0; rti = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
